square_wave_gen: RTL and testbench

//   Programmable square-wave source on sys_clk: period and high time in clock ticks, continuous or N-period burst.

---
 rtl/sq_pkg.sv | 9 +
 rtl/sq_cfg_shadow.sv | 52 +++++
 rtl/square_wave_gen.sv | 98 +++++++++
 tb/tb_square_wave_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// Shared definitions for the square-wave generator and the frequency meter
// that measures it.
package sq_pkg;
  localparam int CNT_W_DEF  = 32;
  localparam int MIN_PERIOD = 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
endpackage

// File: rtl/sq_cfg_shadow.sv
// Period/high-time validation and pending/active double buffer.
// The active pair only changes on a commit, so a running period is never cut short.
module sq_cfg_shadow
  import sq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PERIOD_DEF = 50_000,
  parameter int HIGH_DEF   = 25_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic             commit,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high,
  output logic [CNT_W-1:0] cmt_period,
  output logic [CNT_W-1:0] cmt_high,
  output logic             cfg_err
);
  logic [CNT_W-1:0] pend_period, pend_high;
  logic             cfg_bad, load_ok;

  // A load arriving on the commit cycle is forwarded so it applies to the very next period.
  always_comb begin
    cfg_bad    = (period_in < CNT_W'(MIN_PERIOD)) || (high_in == '0) || (high_in >= period_in);
    load_ok    = cfg_load && !cfg_bad;
    cmt_period = load_ok ? period_in : pend_period;
    cmt_high   = load_ok ? high_in   : pend_high;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_period <= CNT_W'(PERIOD_DEF);
      pend_high   <= CNT_W'(HIGH_DEF);
      act_period  <= CNT_W'(PERIOD_DEF);
      act_high    <= CNT_W'(HIGH_DEF);
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_load && cfg_bad;
      if (load_ok) begin
        pend_period <= period_in;
        pend_high   <= high_in;
      end
      if (commit) begin
        act_period <= cmt_period;
        act_high   <= cmt_high;
      end
    end
  end
endmodule

// File: rtl/square_wave_gen.sv
// Programmable square-wave source: period/high time in ticks, continuous or N-period burst.
// Outputs are registered from next-state values so wave_out and period_done line up with the tick.
module square_wave_gen
  import sq_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PERIOD_DEF   = 50_000,
  parameter int HIGH_DEF     = 25_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic [15:0]      burst_n,
  input  logic             start,
  input  logic             stop,
  output logic             wave_out,
  output logic             busy,
  output logic             period_done,
  output logic             cfg_err,
  output logic [31:0]      cycle_cnt
);
  if (SYS_CLK_FREQ <= 0 || PERIOD_DEF < MIN_PERIOD || HIGH_DEF < 1 || HIGH_DEF >= PERIOD_DEF) begin : g_bad_param
    $error("square_wave_gen: illegal parameter set");
  end

  logic [0:0]       state;
  logic [CNT_W-1:0] tick;
  logic [15:0]      burst_left;
  logic             stop_req;

  logic [CNT_W-1:0] act_period, act_high, cmt_period, cmt_high;
  logic [CNT_W-1:0] nxt_tick, nxt_period, nxt_high;
  logic             idle, last, exit_run, go, nxt_run, commit;

  sq_cfg_shadow #(
    .CNT_W      (CNT_W),
    .PERIOD_DEF (PERIOD_DEF),
    .HIGH_DEF   (HIGH_DEF)
  ) u_shadow (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_load   (cfg_load),
    .period_in  (period_in),
    .high_in    (high_in),
    .commit     (commit),
    .act_period (act_period),
    .act_high   (act_high),
    .cmt_period (cmt_period),
    .cmt_high   (cmt_high),
    .cfg_err    (cfg_err)
  );

  // burst_left==0 means continuous: it is never decremented, so it never hits 1.
  always_comb begin
    idle       = (state == S_IDLE);
    last       = !idle && (tick == act_period - CNT_W'(1));
    exit_run   = last && (stop_req || stop || burst_left == 16'd1);
    go         = idle && start && !stop;
    nxt_run    = idle ? go : !exit_run;
    commit     = idle || last;
    nxt_tick   = commit ? '0 : tick + CNT_W'(1);
    nxt_period = commit ? cmt_period : act_period;
    nxt_high   = commit ? cmt_high : act_high;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      tick        <= '0;
      burst_left  <= '0;
      stop_req    <= 1'b0;
      wave_out    <= 1'b0;
      period_done <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      state       <= nxt_run ? S_RUN : S_IDLE;
      tick        <= nxt_tick;
      wave_out    <= nxt_run && (nxt_tick < nxt_high);
      period_done <= nxt_run && (nxt_tick == nxt_period - CNT_W'(1));
      if (go) begin
        cycle_cnt  <= '0;
        burst_left <= burst_n;
        stop_req   <= 1'b0;
      end else if (last) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        stop_req  <= 1'b0;
        if (burst_left != '0) burst_left <= burst_left - 16'd1;
      end else if (!idle && stop) begin
        stop_req <= 1'b1;
      end
    end
  end

  assign busy = (state == S_RUN);
endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen: burst/config table plus hand sequences for
// mid-run config change, stop, start/stop collision, async reset and default timing.
module tb_square_wave_gen;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] period_in = '0;
  logic [31:0] high_in = '0;
  logic [15:0] burst_n = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wave_out, busy, period_done, cfg_err;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  square_wave_gen dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cfg_load    (cfg_load),
    .period_in   (period_in),
    .high_in     (high_in),
    .burst_n     (burst_n),
    .start       (start),
    .stop        (stop),
    .wave_out    (wave_out),
    .busy        (busy),
    .period_done (period_done),
    .cfg_err     (cfg_err),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load_cfg(input int p, input int h);
    period_in = p;
    high_in   = h;
    cfg_load  = 1'b1;
    step();
    cfg_load  = 1'b0;
  endtask

  task automatic do_start(input int b);
    burst_n = 16'(b);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  typedef struct {
    int period;
    int high;
    int burst;
    bit exp_err;
    int exp_busy;
    int exp_high;
    int exp_cnt;
  } vec_t;

  vec_t vt[8];

  initial begin
    int nb, nh, npd, n, first_pd;
    bit exp_w, exp_pd;

    vt[0] = '{10, 3, 4, 1'b0, 40, 12, 4};
    vt[1] = '{ 2, 1, 1, 1'b0,  2,  1, 1};
    vt[2] = '{ 7, 6, 2, 1'b0, 14, 12, 2};
    vt[3] = '{ 5, 1, 3, 1'b0, 15,  3, 3};
    vt[4] = '{10, 3, 1, 1'b0, 10,  3, 1};
    vt[5] = '{ 5, 5, 1, 1'b1, 10,  3, 1};  // rejected: 10/3 stays in force
    vt[6] = '{ 1, 0, 1, 1'b1, 10,  3, 1};
    vt[7] = '{ 8, 0, 2, 1'b1, 20,  6, 2};

    step();
    step();
    chk("rst_wave", wave_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pd", period_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();

    for (int r = 0; r < 8; r++) begin
      load_cfg(vt[r].period, vt[r].high);
      chk($sformatf("row%0d_cfg_err", r), cfg_err, vt[r].exp_err);
      step();
      chk($sformatf("row%0d_cfg_err_clr", r), cfg_err, 0);
      do_start(vt[r].burst);
      nb = 0; nh = 0; npd = 0; n = 0;
      while (busy && n < 500) begin
        nb++;
        nh  += int'(wave_out);
        npd += int'(period_done);
        step();
        n++;
      end
      chk($sformatf("row%0d_busy_cycles", r), nb, vt[r].exp_busy);
      chk($sformatf("row%0d_high_cycles", r), nh, vt[r].exp_high);
      chk($sformatf("row%0d_period_done", r), npd, vt[r].exp_cnt);
      chk($sformatf("row%0d_cycle_cnt", r), cycle_cnt, vt[r].exp_cnt);
      chk($sformatf("row%0d_wave_idle", r), wave_out, 0);
    end

    // continuous 10/3; 20/15 loaded mid-period, 4/2 loaded on a boundary tick
    load_cfg(10, 3);
    do_start(0);
    for (int i = 0; i < 50; i++) begin
      if (i < 10)      exp_w = (i < 3);
      else if (i < 30) exp_w = ((i - 10) < 15);
      else             exp_w = (((i - 30) % 4) < 2);
      exp_pd = (i == 9) || (i == 29) || (i >= 30 && ((i - 30) % 4) == 3);
      chk($sformatf("cont_wave_%0d", i), wave_out, exp_w);
      chk($sformatf("cont_pd_%0d", i), period_done, exp_pd);
      if (i == 30) chk("cont_cycle_cnt", cycle_cnt, 2);
      cfg_load  = (i == 5) || (i == 29);
      period_in = (i == 5) ? 32'd20 : 32'd4;
      high_in   = (i == 5) ? 32'd15 : 32'd2;
      step();
    end
    cfg_load = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("cont_stopped_busy", busy, 0);
    chk("cont_stopped_wave", wave_out, 0);

    // stop at tick 2 of a 10/3 period: the period still completes
    load_cfg(10, 3);
    do_start(0);
    nb = 0; nh = 0; n = 0;
    while (busy && n < 40) begin
      nb++;
      nh += int'(wave_out);
      stop = (n == 2);
      step();
      n++;
    end
    stop = 1'b0;
    chk("stop_busy_cycles", nb, 10);
    chk("stop_high_cycles", nh, 3);
    chk("stop_cycle_cnt", cycle_cnt, 1);
    chk("stop_wave", wave_out, 0);

    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", busy, 0);
    step();
    chk("start_stop_busy2", busy, 0);
    chk("start_stop_wave", wave_out, 0);

    // async reset in the high phase of the second 10/3 period
    do_start(0);
    for (int i = 0; i < 11; i++) step();
    chk("prerst_wave", wave_out, 1);
    chk("prerst_cycle_cnt", cycle_cnt, 1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("midrst_wave", wave_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cycle_cnt", cycle_cnt, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();

    // restart falls back to the 50_000/25_000 defaults
    do_start(0);
    nh = 0; first_pd = -1;
    for (int i = 0; i < 60000; i++) begin
      nh += int'(wave_out);
      if (period_done) begin
        first_pd = i;
        break;
      end
      step();
    end
    chk("def_first_pd", first_pd, 49999);
    chk("def_high_cycles", nh, 25000);
    step();
    chk("def_pd_pulse", period_done, 0);
    chk("def_wave_next", wave_out, 1);
    chk("def_cycle_cnt", cycle_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
